// File: rtl/instruction_loader.sv
// Host byte-stream loader for the instruction memory: it assembles big-endian words,
// writes them to the memory, verifies the XOR checksum and holds the CPU until a good load completes.
module instruction_loader #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        WE,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam int IW = $clog2(DEPTH) + 1;
    localparam logic [8:0] MAX_LEN = 9'(DEPTH);

    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR} state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx, len, idx_inc;
    logic [1:0]    bcnt;
    logic [7:0]    acc;
    logic [31:0]   word;
    logic          fire, launch, len_bad;

    always_comb begin
        fire    = in_valid && in_ready;
        launch  = start && (state == IDLE || state == DONE || state == ERR);
        len_bad = (in_data == 8'd0) || ({1'b0, in_data} > MAX_LEN);
        idx_inc = idx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE, ERR: if (launch) state_next = LEN;
            LEN:   if (fire) state_next = len_bad ? ERR : DATA;
            DATA:  if (fire && bcnt == 2'd3) state_next = WRITE;
            WRITE: state_next = (idx_inc == len) ? CHECK : DATA;
            CHECK: if (fire) state_next = (in_data == acc) ? DONE : ERR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LEN) || (state == DATA) || (state == CHECK);
        WE       = (state == WRITE);
        busy     = (state == LEN) || (state == DATA) || (state == WRITE) || (state == CHECK);
        done     = (state == DONE);
        error    = (state == ERR);
        cpu_hold = (state != DONE);
    end

    // A/WD are captured with the 4th byte so they are stable for the whole WRITE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx  <= '0;
            len  <= '0;
            bcnt <= '0;
            acc  <= '0;
            word <= '0;
            A    <= '0;
            WD   <= '0;
        end else begin
            if (launch) begin
                idx  <= '0;
                bcnt <= '0;
                acc  <= '0;
                word <= '0;
            end
            if (state == LEN && fire && !len_bad)
                len <= IW'(in_data);
            if (state == DATA && fire) begin
                word <= {word[23:0], in_data};
                acc  <= acc ^ in_data;
                bcnt <= bcnt + 2'd1;
                if (bcnt == 2'd3) begin
                    WD <= {word[23:0], in_data};
                    A  <= {{(30 - IW){1'b0}}, idx, 2'b00};
                end
            end
            if (state == WRITE)
                idx <= idx_inc;
        end
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer side of the instruction memory: receives a byte stream from a host link, assembles big-endian 32-bit instruction words and writes them into the instruction memory's write port at word-aligned addresses. It holds the processor while loading and releases it only after a verified load. It sits between the host byte interface and the instruction memory, ahead of the single-cycle datapath.

## Interface
- DEPTH, 32, number of 32-bit words in the instruction memory; maximum load length
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a load
- in_data  input  8  host byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- WE  output  1  instruction memory write enable, one-cycle pulse per word
- A  output  32  byte address of word being written, always {index, 2'b00}
- WD  output  32  word to write
- busy  output  1  load in progress
- done  output  1  last load completed with good checksum
- error  output  1  last load failed (bad length or checksum)
- cpu_hold  output  1  processor held in reset/stall

## Operation
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_data is sampled only then.
- Frame format: length byte N (words), then 4N data bytes with the MSB first (byte 0 goes to WD[31:24]), then one checksum byte equal to the XOR of all 4N data bytes.
- States:
  - IDLE: waiting for start.
  - LEN: receiving the length byte.
  - DATA: receiving data bytes.
  - WRITE: issuing the memory write.
  - CHECK: receiving the checksum byte.
  - DONE: good load.
  - ERR: failed load.
- IDLE/DONE/ERR + start -> LEN. On entry, the word index, byte counter and XOR accumulator clear, and done and error clear.
- start is ignored in LEN, DATA, WRITE and CHECK.
- LEN: accepted byte N with 1 <= N <= DEPTH -> DATA. N == 0 or N > DEPTH -> ERR, and nothing is written.
- DATA: each accepted byte shifts into a 32-bit assembly register and XORs into the accumulator. After the 4th byte -> WRITE.
- WRITE: WE=1 for exactly this cycle, with A = index*4 and WD = the assembled word; index increments. If the incremented index == N -> CHECK, else -> DATA.
- CHECK: accepted byte == accumulator -> DONE, else -> ERR.
- DONE and ERR persist until the next start.
- in_ready = 1 in LEN, DATA and CHECK; 0 in all other states (including WRITE).
- busy = 1 in LEN, DATA, WRITE and CHECK.
- cpu_hold = 0 only in DONE; 1 in every other state, including after reset.
- A and WD are registered and hold their last value outside WRITE.
- Index counter width is clog2(DEPTH)+1 so that index == DEPTH is representable. A never exceeds (DEPTH-1)*4 during a write.

## Timing
- Reset values: state IDLE, in_ready 0, WE 0, A 0, WD 0, busy 0, done 0, error 0, cpu_hold 1. Assembly register, accumulator and counters are 0.
- start sampled in cycle t -> state LEN, busy=1, in_ready=1 in cycle t+1.
- 4th data byte accepted at edge t -> WE=1 during cycle t+1 -> in_ready=1 again in cycle t+2. Each word costs at least 5 cycles.
- Checksum byte accepted at edge t -> done (or error) = 1 and cpu_hold = 0 (good case only) from cycle t+1.
- in_valid held high with in_ready low: the byte is not consumed; the host must hold it.
- Reset mid-operation: returns immediately to the reset values; partially written memory contents are left as they are; cpu_hold stays 1.
- Restarting after DONE re-asserts cpu_hold the cycle after start.

## Test plan
- Reset, then start, then N=1 and bytes 20 08 00 05, checksum 2D -> one WE pulse with A=0x00000000 and WD=0x20080005, then done=1, error=0, cpu_hold=0.
- N=2 with words 0x00000FA0 and 0x00001F40 and a correct checksum -> WE at A=0x0 then A=0x4, WD values matching, done=1; in_ready=0 during each WRITE cycle.
- Good frame with checksum byte corrupted (XOR 0x01) -> both words written, error=1, done=0, cpu_hold=1.
- Length byte 0x00 and 0x21 (DEPTH=32) -> ERR immediately, no WE, in_ready=0 afterwards.
- N=32 full load with in_valid toggling randomly -> 32 writes at A=0x00..0x7C, no byte lost or duplicated, done=1.
- Assert reset after the 2nd byte of word 1 -> all outputs at reset values, next start accepts a fresh frame; start pulse mid-DATA is ignored.
